// File: rtl/genbus_master.sv
// Initiator end of the generic data bus: accepts one core request at a time, decodes the
// target slave, drives held strobes, honours slave wait states and aborts on timeout.
module genbus_master #(
  parameter int NSLAVES  = 4,
  parameter int SLAVE_AW = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [15:0]             i_req_adr,
  input  logic [1:0]              i_req_we,
  input  logic [1:0]              i_req_re,
  input  logic [15:0]             i_req_wdata,
  output logic                    o_resp_valid,
  output logic [15:0]             o_resp_rdata,
  output logic                    o_resp_err,
  output logic [15:0]             o_adr,
  output logic [15:0]             o_mdata,
  output logic [1:0]              o_we,
  output logic [1:0]              o_re,
  output logic [NSLAVES-1:0]      o_sel,
  input  logic [16*NSLAVES-1:0]   i_s_sdata,
  input  logic [NSLAVES-1:0]      i_s_ws
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_resp_valid, w_resp_valid_nxt;
  logic                 r_resp_err, w_resp_err_nxt;
  logic [15:0]          r_rdata, w_rdata_nxt;
  logic [15:0]          r_adr, w_adr_nxt;
  logic [15:0]          r_mdata, w_mdata_nxt;
  logic [1:0]           r_we, w_we_nxt;
  logic [1:0]           r_re, w_re_nxt;
  logic [NSLAVES-1:0]   r_sel, w_sel_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;

  logic [3:0]           w_idx;
  logic                 w_dec_err, w_empty, w_accept, w_ws, w_timeout;
  logic [1:0]           w_re_eff;
  logic [NSLAVES-1:0]   w_onehot;
  logic [15:0]          w_sdata, w_lane_mask;

  assign w_idx       = i_req_adr[SLAVE_AW+3:SLAVE_AW];
  assign w_dec_err   = ({1'b0, w_idx} >= 5'(NSLAVES));
  assign w_re_eff    = (i_req_we != 2'b00) ? 2'b00 : i_req_re;  // write wins over read
  assign w_empty     = (i_req_we == 2'b00) && (w_re_eff == 2'b00);
  assign w_accept    = i_req_valid && r_ready && (r_state == ST_IDLE);
  assign w_ws        = |(i_s_ws & r_sel);
  assign w_timeout   = (r_cnt == 8'(TIMEOUT));
  assign w_lane_mask = {{8{r_re[1]}}, {8{r_re[0]}}};

  always_comb begin
    w_onehot = '0;
    w_sdata  = 16'h0000;
    for (int k = 0; k < NSLAVES; k++) begin
      w_onehot[k] = (w_idx == 4'(k));
      if (r_sel[k]) begin
        w_sdata = w_sdata | i_s_sdata[16*k +: 16];
      end else begin
        w_sdata = w_sdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_dec_err && !w_empty) w_state_nxt = ST_BUS;
        else                                   w_state_nxt = ST_IDLE;
      end
      ST_BUS: begin
        if (!w_ws || w_timeout) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_BUS;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields only change on accept or completion.
  always_comb begin
    w_ready_nxt      = r_ready;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = r_resp_err;
    w_rdata_nxt      = r_rdata;
    w_adr_nxt        = r_adr;
    w_mdata_nxt      = r_mdata;
    w_we_nxt         = r_we;
    w_re_nxt         = r_re;
    w_sel_nxt        = r_sel;
    w_cnt_nxt        = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          if (w_dec_err || w_empty) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = w_dec_err;
            w_rdata_nxt      = 16'h0000;
          end else begin
            w_ready_nxt = 1'b0;
            w_adr_nxt   = i_req_adr;
            w_mdata_nxt = i_req_wdata;
            w_we_nxt    = i_req_we;
            w_re_nxt    = w_re_eff;
            w_sel_nxt   = w_onehot;
            w_cnt_nxt   = 8'd0;
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      ST_BUS: begin
        if (!w_ws || w_timeout) begin
          w_ready_nxt      = 1'b1;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = w_ws;
          w_rdata_nxt      = w_ws ? 16'h0000 : (w_sdata & w_lane_mask);
          w_adr_nxt        = 16'h0000;
          w_mdata_nxt      = 16'h0000;
          w_we_nxt         = 2'b00;
          w_re_nxt         = 2'b00;
          w_sel_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_ready_nxt = 1'b0;
    endcase
  end

  // Output registers; reset clears everything so a mid-access reset issues no response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 16'h0000;
      r_adr        <= 16'h0000;
      r_mdata      <= 16'h0000;
      r_we         <= 2'b00;
      r_re         <= 2'b00;
      r_sel        <= '0;
      r_cnt        <= 8'd0;
    end else begin
      r_ready      <= w_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_rdata      <= w_rdata_nxt;
      r_adr        <= w_adr_nxt;
      r_mdata      <= w_mdata_nxt;
      r_we         <= w_we_nxt;
      r_re         <= w_re_nxt;
      r_sel        <= w_sel_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign o_req_ready  = r_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_rdata;
  assign o_adr        = r_adr;
  assign o_mdata      = r_mdata;
  assign o_we         = r_we;
  assign o_re         = r_re;
  assign o_sel        = r_sel;

endmodule

// File: doc/genbus_master.md
# genbus_master

Initiator end of the internal generic data bus. It takes single load/store requests from a core-side valid/ready port, decodes the target peripheral from the address, and drives the shared `adr`/`mdata`/`we`/`re` strobes. It then honours the selected peripheral's `ws` wait-state, returns read data or an error, and aborts any access that exceeds a wait-state budget. It sits between the CPU core and the bus peripherals (ports, timers, ...), which implement the slave end.

## Interface
- `NSLAVES`, default 4: number of peripheral slots (slave IDs 0..NSLAVES-1); 1..16.
- `SLAVE_AW`, default 4: address bits decoded inside one slave window.
- `TIMEOUT`, default 15: maximum wait-state cycles before an access is aborted; 1..255.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  block can accept a request.
- `req_adr`  in  16  byte-pair address.
- `req_we`  in  2  byte write enables (bit0 = [7:0], bit1 = [15:8]).
- `req_re`  in  2  byte read enables.
- `req_wdata`  in  16  write data.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  16  read data; unread byte lanes are 0.
- `resp_err`  out  1  decode error or timeout.
- `adr`  out  16  bus address.
- `mdata`  out  16  bus write data.
- `we`  out  2  bus write strobes.
- `re`  out  2  bus read strobes.
- `sel`  out  NSLAVES  one-hot slave select.
- `s_sdata`  in  16*NSLAVES  slave read data; slave k occupies [16k+15:16k].
- `s_ws`  in  NSLAVES  slave wait-state flags.

## Operation
- Slave index = `req_adr[SLAVE_AW+3:SLAVE_AW]`. An index ≥ NSLAVES is a decode error.
- FSM states: IDLE, BUS.
- **IDLE**
  - `req_ready` = 1 (0 while `rst`).
  - On `req_valid & req_ready`, latch the request.
  - If it is a valid decode with nonzero strobes, go to BUS: drive `adr`/`mdata`/`sel`/`we`/`re` from the next edge.
  - If it is a decode error, stay in IDLE and pulse `resp_valid` with `resp_err`=1, `resp_rdata`=0, no bus strobes.
  - If `we`=`re`=0, stay in IDLE and pulse `resp_valid`, `resp_err`=0, `resp_rdata`=0.
- **Write priority:** if `req_we`≠0, `re` is forced to 0 (write wins).
- **BUS**
  - Strobes are held constant every cycle in BUS.
  - The wait counter starts at 0.
  - Each cycle, sample the selected `s_ws`:
    - 0: complete. Capture the selected `s_sdata` masked by `re` lanes into `resp_rdata`, set `resp_err`=0, clear strobes/`sel`/`adr`/`mdata` to 0, go to IDLE, and pulse `resp_valid` next cycle.
    - 1: increment the counter. When the counter reaches TIMEOUT with `ws` still 1, abort: clear strobes, go to IDLE, `resp_valid` with `resp_err`=1, `resp_rdata`=0.
- Slaves must treat held write strobes idempotently. The master never issues two accesses without an IDLE cycle between them.
- **Reset mid-BUS:** all outputs clear at the reset edge, the FSM returns to IDLE, and no response is issued.
- Reset values of all outputs are 0, including `req_ready` while `rst` is high.

## Timing
- Accept at edge N. Strobes are valid from N to N+1+W (W = wait cycles).
- `resp_valid` is high during cycle N+2+W, with `resp_rdata`/`resp_err` valid only then.
- `req_ready` rises together with `resp_valid`. Back-to-back zero-wait throughput is one access per 2 cycles.
- Decode-error and empty-strobe responses: `resp_valid` in cycle N+1.
- Timeout response: `resp_valid` in cycle N+2+TIMEOUT. Strobes are held exactly TIMEOUT+1 cycles.
- All outputs are registered; none depend combinationally on `s_ws`, `s_sdata` or `req_*`.

## Test plan
- **Zero-wait read:** `req_adr`=0x0014 (slave 1, offset 4), `re`=2'b01, slave 1 `sdata`=0xAB5A, `ws`=0 → `re`=01 and `sel`=0010 for one cycle; `resp_rdata`=0x005A, `resp_err`=0, two cycles after accept.
- **Byte write with waits:** `req_we`=2'b10, `wdata`=0x7700, slave 0 holds `ws`=1 for 3 cycles → `we`=10, `mdata`=0x7700 held 4 cycles; `resp_valid` 5 cycles after accept, `err`=0.
- **Timeout:** TIMEOUT=15, slave 2 `ws` stuck 1 → strobes for 16 cycles, then `resp_err`=1, `resp_rdata`=0; the next request is accepted normally.
- **Decode error:** NSLAVES=4, `req_adr`=0x0050 → no strobe or `sel` activity; `resp_err`=1 in the cycle after accept.
- **Both strobes:** `we`=11 and `re`=11 → bus shows `we`=11, `re`=00; `resp_rdata`=0.
- **Reset mid-access:** assert `rst` during the BUS wait → next cycle all outputs 0, no `resp_valid`, `req_ready`=1 after `rst` deasserts.
